// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration-port arbiter.
// Optional build macro used by the arbiter: FLL_CFG_TIMEOUT_EN.
package fll_cfg_pkg;

    // Native widths of the FLL configuration port.
    localparam int AW = 2;
    localparam int DW = 32;

    // Read data returned to a requester whose transaction timed out.
    localparam logic [31:0] FLL_CFG_ERR_RDATA = 32'hBADC_AB1E;

    // Arbiter sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } fll_cfg_state_e;

    // One latched configuration request.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          web;
    } fll_cfg_req_t;

endpackage

// File: rtl/fll_cfg_rr_pick.sv
// Round-robin picker: returns the first asserted request at or above the
// pointer, scanning upward and wrapping at NUM_REQ. Purely combinational.
module fll_cfg_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               valid_o,
    output logic [IW-1:0]      idx_o
);

    localparam logic [IW:0] NREQ = (IW+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      off;
    logic [IW:0]        sum;

    // Rotate so bit 0 is the pointer position, take the lowest set bit, then
    // map the offset back to an absolute index modulo NUM_REQ.
    always_comb begin
        rot     = NUM_REQ'({req_i, req_i} >> ptr_i);
        valid_o = 1'b0;
        off     = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                valid_o = 1'b1;
                off     = IW'(j);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        idx_o = sum[IW-1:0];
    end

endmodule

// File: rtl/fll_cfg_arbiter.sv
// Round-robin arbiter sharing the single FLL configuration port between
// NUM_REQ requesters. Owns the full 4-phase req/ack sequence toward the FLL
// and returns a one-cycle ack with registered read data to the winner.
// Build macro FLL_CFG_TIMEOUT_EN adds an ISSUE-state timeout that completes
// the transaction with err_o=1 and FLL_CFG_ERR_RDATA.
module fll_cfg_arbiter
    import fll_cfg_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_REQ-1:0]             web_i,
    output logic [NUM_REQ-1:0]             ack_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           err_o,
    output logic                           fll_req_o,
    input  logic                           fll_ack_i,
    output logic [ADDR_WIDTH-1:0]          fll_addr_o,
    output logic [DATA_WIDTH-1:0]          fll_wdata_o,
    output logic                           fll_web_o,
    input  logic [DATA_WIDTH-1:0]          fll_rdata_i
);

    localparam int            IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    fll_cfg_state_e          state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           win_q, win_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    web_q, web_d;
    logic [DATA_WIDTH-1:0]   cap_q, cap_d;
    logic                    fll_req_q, fll_req_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    pick_vld;
    logic [IW-1:0]           pick_idx;

`ifdef FLL_CFG_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    timeout;
`endif

    fll_cfg_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

`ifdef FLL_CFG_TIMEOUT_EN
    // Timeout fires on the last allowed ISSUE cycle unless the FLL acks in it.
    always_comb begin
        timeout = (state_q == ISSUE) && !fll_ack_i && (cnt_q == CNT_LAST);
    end
`endif

    // Next-state and registered-output logic of the transaction sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        web_d     = web_q;
        cap_d     = cap_q;
        fll_req_d = fll_req_q;
        ack_d     = '0;
        rdata_d   = '0;
`ifdef FLL_CFG_TIMEOUT_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Winner's inputs are sampled only here; later changes are ignored.
                if (pick_vld) begin
                    win_d     = pick_idx;
                    addr_d    = addr_i[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d   = wdata_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    web_d     = web_i[pick_idx];
                    ptr_d     = (pick_idx == LAST) ? '0 : pick_idx + IW'(1);
                    fll_req_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (fll_ack_i) begin
                    // Writes capture too; the data is simply returned with the ack.
                    cap_d     = fll_rdata_i;
                    fll_req_d = 1'b0;
                    state_d   = DRAIN;
                end
`ifdef FLL_CFG_TIMEOUT_EN
                else if (timeout) begin
                    fll_req_d    = 1'b0;
                    ack_d[win_q] = 1'b1;
                    rdata_d      = DATA_WIDTH'(FLL_CFG_ERR_RDATA);
                    err_d        = 1'b1;
                    state_d      = RESP;
                end
`endif
            end
            DRAIN: begin
                // Complete the 4-phase handshake before acknowledging upstream.
                if (!fll_ack_i) begin
                    ack_d[win_q] = 1'b1;
                    rdata_d      = cap_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                fll_req_d = 1'b0;
            end
        endcase
    end

`ifdef FLL_CFG_TIMEOUT_EN
    // Counter runs only while staying in ISSUE, so it reads 0 in the first ISSUE cycle.
    always_comb begin
        cnt_d = ((state_q == ISSUE) && (state_d == ISSUE)) ? cnt_q + CW'(1) : '0;
    end
`endif

    // State, request latches and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            web_q     <= 1'b1;
            cap_q     <= '0;
            fll_req_q <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
`ifdef FLL_CFG_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            web_q     <= web_d;
            cap_q     <= cap_d;
            fll_req_q <= fll_req_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
`ifdef FLL_CFG_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign fll_req_o   = fll_req_q;
    assign fll_addr_o  = addr_q;
    assign fll_wdata_o = wdata_q;
    assign fll_web_o   = web_q;
`ifdef FLL_CFG_TIMEOUT_EN
    assign err_o       = err_q;
`else
    assign err_o       = 1'b0;
`endif

endmodule
